// File: rtl/simplez_tx.sv
// simplez_tx: 8N1 serial transmitter with a one-byte holding register.
// A buffered byte is reloaded into the shifter at the stop bit for gapless frames.
module simplez_tx #(
  parameter int BAUDDIV = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       wr,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  localparam logic [15:0] BMAX = 16'(BAUDDIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        full_q, full_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  logic bit_end;
  logic reload;
  logic accept;

  assign bit_end = (cnt_q == BMAX);
  assign reload  = full_q &&
                   ((state_q == S_IDLE) ||
                    ((state_q == S_STOP) && bit_end));
  assign accept  = wr && !full_q;

  assign ready = !full_q;
  assign busy  = busy_q;
  assign tx    = tx_q;

  // State and datapath registers; reset idles the line high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      full_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (full_q) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = full_q ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register, shifter, baud counter and bit index updates.
  always_comb begin
    hold_d  = hold_q;
    full_d  = full_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (reload) begin
      full_d  = 1'b0;
      shift_d = hold_q;
    end else if (accept) begin
      full_d = 1'b1;
      hold_d = data;
    end
    if (state_q == S_IDLE || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    if (reload || state_q == S_START) begin
      idx_d = '0;
    end else if (state_q == S_DATA && bit_end) begin
      idx_d = idx_q + 3'd1;
    end
  end

  // Registered line and busy values derived from the upcoming state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    unique case (state_d)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      S_DATA: begin
        tx_d   = shift_d[idx_d];
        busy_d = 1'b1;
      end
      S_STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_simplez_tx.sv
// tb_simplez_tx: random and directed stimulus for simplez_tx,
// compared cycle by cycle against a frame-timeline reference model.
module tb_simplez_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn4 = 1'b1;
  logic       wr4   = 1'b0;
  logic [7:0] d4    = '0;
  logic       rdy4, busy4, tx4;

  logic       rstn1 = 1'b1;
  logic       wr1   = 1'b0;
  logic [7:0] d1    = '0;
  logic       rdy1, busy1, tx1;

  simplez_tx #(.BAUDDIV(4)) u_b4 (
    .clk(clk), .rstn(rstn4), .data(d4), .wr(wr4),
    .ready(rdy4), .busy(busy4), .tx(tx4)
  );

  simplez_tx #(.BAUDDIV(1)) u_b1 (
    .clk(clk), .rstn(rstn1), .data(d1), .wr(wr1),
    .ready(rdy1), .busy(busy1), .tx(tx1)
  );

  int sel;
  int mb;
  int n_chk;
  int n_pass;

  bit         m_full;
  logic [7:0] m_hold;
  bit         m_act;
  logic [7:0] m_cur;
  int         m_t;

  logic [9:0] pat;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_act) return 1'b1;
    k = m_t / mb;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  task automatic model_reset();
    m_full = 0;
    m_hold = '0;
    m_act  = 0;
    m_cur  = '0;
    m_t    = 0;
  endtask

  task automatic model_step(input logic w, input logic [7:0] d);
    bit reload;
    reload = m_full && (!m_act || m_t == 10*mb - 1);
    if (m_act) begin
      m_t++;
      if (m_t == 10*mb) m_act = 0;
    end
    if (reload) begin
      m_act  = 1;
      m_t    = 0;
      m_cur  = m_hold;
      m_full = 0;
    end else if (w && !m_full) begin
      m_full = 1;
      m_hold = d;
    end
  endtask

  function automatic logic o_tx();
    return sel ? tx1 : tx4;
  endfunction

  function automatic logic o_busy();
    return sel ? busy1 : busy4;
  endfunction

  function automatic logic o_rdy();
    return sel ? rdy1 : rdy4;
  endfunction

  task automatic drive(input logic w, input logic [7:0] d);
    if (sel != 0) begin
      wr1 = w;
      d1  = d;
    end else begin
      wr4 = w;
      d4  = d;
    end
  endtask

  task automatic tick(input logic w, input logic [7:0] d);
    drive(w, d);
    @(posedge clk);
    model_step(w, d);
    @(negedge clk);
    check("tx", 32'(o_tx()), 32'(exp_tx()));
    check("busy", 32'(o_busy()), 32'(m_act));
    check("ready", 32'(o_rdy()), 32'(!m_full));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic rand_run(input int n);
    logic w;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      w = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      tick(w, d);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    sel    = 1;
    mb     = 1;
    model_reset();

    #1;
    rstn4 = 1'b0;
    rstn1 = 1'b0;
    #2;
    check("rst_tx4", 32'(tx4), 32'd1);
    check("rst_rdy4", 32'(rdy4), 32'd1);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_tx1", 32'(tx1), 32'd1);
    check("rst_rdy1", 32'(rdy1), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    @(negedge clk);
    rstn4 = 1'b1;
    rstn1 = 1'b1;

    // BAUDDIV=1, single 0x80 frame
    tick(1'b1, 8'h80);
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 8'h00);
      pat = {pat[8:0], tx1};
    end
    check("b1_frame80", 32'(pat), 32'b0000000011);
    idle(3);
    rand_run(300);
    idle(20);

    // switch to the BAUDDIV=4 instance
    sel = 0;
    mb  = 4;
    model_reset();

    tick(1'b1, 8'h55);
    idle(45);

    tick(1'b1, 8'hA5);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h3C);
    idle(90);

    tick(1'b1, 8'h11);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h22);
    tick(1'b1, 8'h33);
    idle(90);

    // reset in the middle of data bit 3 of 0xFF
    tick(1'b1, 8'hFF);
    for (int i = 0; i < 40 && !(m_act && m_t == 17); i++)
      tick(1'b0, 8'h00);
    check("pre_rst_busy", 32'(busy4), 32'd1);
    #2;
    rstn4 = 1'b0;
    #1;
    check("midrst_tx", 32'(tx4), 32'd1);
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_rdy", 32'(rdy4), 32'd1);
    model_reset();
    @(negedge clk);
    rstn4 = 1'b1;
    tick(1'b1, 8'h01);
    idle(45);

    // reset while the start bit is on the line
    tick(1'b1, 8'hF0);
    tick(1'b0, 8'h00);
    check("start_tx0", 32'(tx4), 32'd0);
    #2;
    rstn4 = 1'b0;
    #1;
    check("startrst_tx", 32'(tx4), 32'd1);
    model_reset();
    @(negedge clk);
    rstn4 = 1'b1;
    idle(3);

    rand_run(600);
    idle(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/simplez_tx.md
SIMPLEZ_TX -- requirements
Module: simplez_tx

Interface
REQ-001 Parameter BAUDDIV, default 104, clock cycles per serial bit (12 MHz / 115200 baud); legal range 1..65535.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 data  input  8  byte written by the processor's output instruction.
REQ-005 wr  input  1  write strobe, sampled on the rising edge of clk.
REQ-006 ready  output  1  holding register empty; a write is accepted only while high.
REQ-007 busy  output  1  shifter transmitting a frame (START, DATA or STOP state).
REQ-008 tx  output  1  serial line, 8N1, idle high.

Function
REQ-009 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held for exactly BAUDDIV clock cycles.
REQ-010 Block SHALL contain a one-byte holding register plus a separate 8-bit shift register, allowing one write to be buffered while a frame is in flight.
REQ-011 On an edge with wr=1 and ready=1, data SHALL load into the holding register and ready SHALL be 0 after that edge.
REQ-012 On an edge with wr=1 and ready=0, the write SHALL be ignored: holding register, ready and the frame in progress are unchanged.
REQ-013 FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1, busy=0; on the first edge where the holding register is full, go to START, copy holding to the shifter, set ready=1, clear the baud and bit counters.
REQ-015 Latency: byte written at edge k with shifter idle gives tx=0 from edge k+1.
REQ-016 START: tx=0 for BAUDDIV cycles, then DATA with bit index 0.
REQ-017 DATA: tx=shifter bit[index] for BAUDDIV cycles per bit; index increments 0..7; after bit 7 completes, go to STOP.
REQ-018 STOP: tx=1 for BAUDDIV cycles; at completion, go to START (reload as in REQ-014) if the holding register is full, else to IDLE.
REQ-019 Back-to-back frames SHALL have no idle gap: the next start bit follows the stop bit with no extra cycle; frame period = 10*BAUDDIV cycles.
REQ-020 Baud counter SHALL be 16 bits, count 0..BAUDDIV-1 and wrap to 0 at each bit boundary; with BAUDDIV=1 every bit lasts one cycle.
REQ-021 A write accepted on the same edge that the shifter reloads from the holding register SHALL NOT occur, because ready=0 on that edge; a write on the following edge (ready=1) SHALL be accepted.
REQ-022 tx and busy SHALL be registered outputs, free of combinational glitches.
REQ-023 Changes to data while ready=0 SHALL NOT alter the buffered or transmitting byte.

Reset
REQ-024 While rstn=0, asynchronously: tx=1, ready=1, busy=0, state IDLE, holding register empty, shift register, baud counter and bit index all 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame and drive tx=1 immediately, without waiting for a clock edge; the buffered byte is discarded.
REQ-026 After rstn rises, the first write SHALL be accepted on the first rising edge at which wr=1.

Verification
REQ-027 BAUDDIV=4, write 0x55 once -> tx = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles (40 cycles total); busy=1 throughout the frame; then tx=1, busy=0.
REQ-028 BAUDDIV=4, write 0xA5, then 0x3C as soon as ready=1 -> two contiguous 40-cycle frames with no idle cycle between the stop bit and the second start bit; data bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
REQ-029 BAUDDIV=4: write 0x11, then 0x22 (buffered), then 0x33 while ready=0 -> only 0x11 and 0x22 are transmitted; 0x33 is dropped.
REQ-030 BAUDDIV=4, write 0xFF, pull rstn low during bit 3 -> tx=1 within the same cycle, ready=1, busy=0; a later write of 0x01 transmits a clean frame.
REQ-031 BAUDDIV=1, write 0x80 -> 10-cycle frame: tx = 0,0,0,0,0,0,0,0,1,1.
REQ-032 Latency check, BAUDDIV=4: write at edge k with the block idle -> tx=0 and busy=1 after edge k+1; ready returns to 1 after edge k+1.
